// File: rtl/mem_access_unit.sv
// Memory access unit: sequences loads and stores onto a doubleword memory
// with a synchronous read port, using read-modify-write for sub-doubleword stores.
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN (misaligned requests
// raise MisalignExc through an EXC state instead of being force-aligned).
// Ports:
//   clk, Reset (async, active low)
//   LoadMDR, DMemWrite, tam, LoadUnsigned, Address, StoreData : request
//   MemAddr, MemWrData, MemWr, MemRdData                      : memory side
//   MDROut, Busy, Done, MisalignExc                           : status/result
module mem_access_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        LoadMDR,
    input  logic        DMemWrite,
    input  logic [1:0]  tam,
    input  logic        LoadUnsigned,
    input  logic [63:0] Address,
    input  logic [63:0] StoreData,
    output logic [63:0] MemAddr,
    output logic [63:0] MemWrData,
    output logic        MemWr,
    input  logic [63:0] MemRdData,
    output logic [63:0] MDROut,
    output logic        Busy,
    output logic        Done,
    output logic        MisalignExc
);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE, RD, CAP, MERGE, WR, EXC
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD, CAP, MERGE, WR
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] addr_q;
    logic [1:0]  tam_q;
    logic        uns_q;
    logic [63:0] sdata_q;
    logic        st_q;
    logic [63:0] mdr_q;
    logic [63:0] wdata_q;
    logic        done_q, done_d;
    logic        accept;

    logic [2:0]  off;
    logic [63:0] shifted;
    logic [63:0] ext;
    logic [7:0]  bmask;
    logic [7:0]  bmask_sh;
    logic [63:0] bitmask;
    logic [63:0] sd_sh;
    logic [63:0] merged;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic mis;

    always_comb begin
        case (tam)
            2'b00:   mis = |Address[2:0];
            2'b01:   mis = |Address[1:0];
            2'b10:   mis = Address[0];
            default: mis = 1'b0;
        endcase
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control outputs
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        done_d      = 1'b0;
        MemWr       = 1'b0;
        MisalignExc = 1'b0;
        case (state_q)
            IDLE: begin
                if (LoadMDR || DMemWrite) begin
                    accept = 1'b1;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                    if (mis) begin
                        state_d = EXC;
                    end else
`endif
                    if (DMemWrite) begin
                        state_d = (tam == 2'b00) ? WR : RD;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:    state_d = st_q ? MERGE : CAP;
            CAP: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            MERGE: state_d = WR;
            WR: begin
                MemWr   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            EXC: begin
                MisalignExc = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Byte offset; without the check the bits below the access
    // size are dropped so the access is naturally aligned.
    always_comb begin
        off = addr_q[2:0];
`ifndef MEM_ACCESS_MISALIGN_CHECK_EN
        case (tam_q)
            2'b00:   off = 3'b000;
            2'b01:   off = {addr_q[2], 2'b00};
            2'b10:   off = {addr_q[2:1], 1'b0};
            default: off = addr_q[2:0];
        endcase
`endif
    end

    // Load extraction
    always_comb begin
        shifted = MemRdData >> {off, 3'b000};
        case (tam_q)
            2'b00: ext = shifted;
            2'b01: ext = uns_q ? {32'd0, shifted[31:0]}
                               : {{32{shifted[31]}}, shifted[31:0]};
            2'b10: ext = uns_q ? {48'd0, shifted[15:0]}
                               : {{48{shifted[15]}}, shifted[15:0]};
            default: ext = uns_q ? {56'd0, shifted[7:0]}
                                 : {{56{shifted[7]}}, shifted[7:0]};
        endcase
    end

    // Store merge: byte-lane mask placed at the offset
    always_comb begin
        case (tam_q)
            2'b00:   bmask = 8'hFF;
            2'b01:   bmask = 8'h0F;
            2'b10:   bmask = 8'h03;
            default: bmask = 8'h01;
        endcase
        bmask_sh = bmask << off;
        for (int i = 0; i < 8; i++) begin
            bitmask[i*8 +: 8] = {8{bmask_sh[i]}};
        end
        sd_sh  = sdata_q << {off, 3'b000};
        merged = (MemRdData & ~bitmask) | (sd_sh & bitmask);
    end

    // Request latch and datapath registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= 64'd0;
            tam_q   <= 2'b00;
            uns_q   <= 1'b0;
            sdata_q <= 64'd0;
            st_q    <= 1'b0;
            mdr_q   <= 64'd0;
            wdata_q <= 64'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            if (accept) begin
                addr_q  <= Address;
                tam_q   <= tam;
                uns_q   <= LoadUnsigned;
                sdata_q <= StoreData;
                st_q    <= DMemWrite;
                if (DMemWrite) begin
                    wdata_q <= StoreData;
                end
            end
            if (state_q == MERGE) begin
                wdata_q <= merged;
            end
            if (state_q == CAP) begin
                mdr_q <= ext;
            end
        end
    end

    assign MemAddr   = {addr_q[63:3], 3'b000};
    assign MemWrData = wdata_q;
    assign MDROut    = mdr_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed loads/stores against a
// synchronous memory model, scoreboarded write/done/exception events.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        LoadMDR = 1'b0;
    logic        DMemWrite = 1'b0;
    logic [1:0]  tam = 2'b00;
    logic        LoadUnsigned = 1'b0;
    logic [63:0] Address = 64'd0;
    logic [63:0] StoreData = 64'd0;
    logic [63:0] MemAddr;
    logic [63:0] MemWrData;
    logic        MemWr;
    logic [63:0] MemRdData;
    logic [63:0] MDROut;
    logic        Busy;
    logic        Done;
    logic        MisalignExc;

    mem_access_unit dut (
        .clk          (clk),
        .Reset        (Reset),
        .LoadMDR      (LoadMDR),
        .DMemWrite    (DMemWrite),
        .tam          (tam),
        .LoadUnsigned (LoadUnsigned),
        .Address      (Address),
        .StoreData    (StoreData),
        .MemAddr      (MemAddr),
        .MemWrData    (MemWrData),
        .MemWr        (MemWr),
        .MemRdData    (MemRdData),
        .MDROut       (MDROut),
        .Busy         (Busy),
        .Done         (Done),
        .MisalignExc  (MisalignExc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem [logic [63:0]];
    always @(posedge clk) begin
        MemRdData <= mem.exists(MemAddr) ? mem[MemAddr] : 64'd0;
    end

    typedef struct packed {
        int          cyc;
        logic [63:0] a;
        logic [63:0] d;
    } ev_t;

    ev_t wr_q[$], done_q[$], exc_q[$];
    ev_t ex_wr_q[$], ex_done_q[$], ex_exc_q[$];

    always @(negedge clk) begin
        if (MemWr === 1'b1) wr_q.push_back(ev_t'{cyc, MemAddr, MemWrData});
        if (Done === 1'b1) done_q.push_back(ev_t'{cyc, 64'd0, MDROut});
        if (MisalignExc === 1'b1) exc_q.push_back(ev_t'{cyc, 64'd0, 64'd0});
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st,
                         input logic [63:0] a, input logic [1:0] t,
                         input logic u, input logic [63:0] sd,
                         input int hold, output int tr);
        @(negedge clk);
        LoadMDR = ld;
        DMemWrite = st;
        Address = a;
        tam = t;
        LoadUnsigned = u;
        StoreData = sd;
        @(posedge clk);
        #1;
        tr = cyc;
        repeat (hold - 1) begin
            @(posedge clk);
            #1;
        end
        LoadMDR = 1'b0;
        DMemWrite = 1'b0;
    endtask

    task automatic drain(input string tag);
        ev_t o, e;
        repeat (8) @(negedge clk);
        #1;
        chk({tag, ".n_done"}, 64'(done_q.size()), 64'(ex_done_q.size()));
        chk({tag, ".n_wr"}, 64'(wr_q.size()), 64'(ex_wr_q.size()));
        chk({tag, ".n_exc"}, 64'(exc_q.size()), 64'(ex_exc_q.size()));
        while (done_q.size() > 0 && ex_done_q.size() > 0) begin
            o = done_q.pop_front();
            e = ex_done_q.pop_front();
            chk({tag, ".done_cyc"}, 64'(o.cyc), 64'(e.cyc));
            chk({tag, ".mdr"}, o.d, e.d);
        end
        while (wr_q.size() > 0 && ex_wr_q.size() > 0) begin
            o = wr_q.pop_front();
            e = ex_wr_q.pop_front();
            chk({tag, ".wr_cyc"}, 64'(o.cyc), 64'(e.cyc));
            chk({tag, ".wr_addr"}, o.a, e.a);
            chk({tag, ".wr_data"}, o.d, e.d);
        end
        while (exc_q.size() > 0 && ex_exc_q.size() > 0) begin
            o = exc_q.pop_front();
            e = ex_exc_q.pop_front();
            chk({tag, ".exc_cyc"}, 64'(o.cyc), 64'(e.cyc));
        end
        done_q.delete();
        wr_q.delete();
        exc_q.delete();
        ex_done_q.delete();
        ex_wr_q.delete();
        ex_exc_q.delete();
    endtask

    initial begin
        int tr;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(Busy), 64'd0);
        chk("rst.memwr", 64'(MemWr), 64'd0);
        chk("rst.done", 64'(Done), 64'd0);
        chk("rst.exc", 64'(MisalignExc), 64'd0);
        chk("rst.mdr", MDROut, 64'd0);
        chk("rst.wdata", MemWrData, 64'd0);
        chk("rst.addr", MemAddr, 64'd0);
        @(posedge clk);
        #2;
        Reset = 1'b1;

        // Signed byte load, first edge after reset release
        mem[64'h1000] = 64'h0000_0000_8000_0000;
        issue(1, 0, 64'h1003, 2'b11, 0, 64'd0, 1, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'hFFFF_FFFF_FFFF_FF80});
        drain("ld_b_s");

        // Unsigned word load
        mem[64'h1000] = 64'h8765_4321_0000_0000;
        issue(1, 0, 64'h1004, 2'b01, 1, 64'd0, 1, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'h0000_0000_8765_4321});
        drain("ld_w_u");

        // Halfword store (RMW); MDROut must hold
        mem[64'h2000] = 64'h1111_2222_3333_4444;
        issue(0, 1, 64'h2002, 2'b10, 0, 64'hAAAA_BBBB_CCCC_1234, 1, tr);
        ex_wr_q.push_back(ev_t'{tr + 2, 64'h2000, 64'h1111_2222_1234_4444});
        ex_done_q.push_back(ev_t'{tr + 3, 64'd0, 64'h0000_0000_8765_4321});
        drain("st_h");

        // Doubleword store
        issue(0, 1, 64'h3000, 2'b00, 0, 64'hDEAD_BEEF_0123_4567, 1, tr);
        ex_wr_q.push_back(ev_t'{tr, 64'h3000, 64'hDEAD_BEEF_0123_4567});
        ex_done_q.push_back(ev_t'{tr + 1, 64'd0, 64'h0000_0000_8765_4321});
        drain("st_d");

        // Both strobes: treated as store
        issue(1, 1, 64'h3000, 2'b00, 0, 64'h0F0E_0D0C_0B0A_0908, 1, tr);
        ex_wr_q.push_back(ev_t'{tr, 64'h3000, 64'h0F0E_0D0C_0B0A_0908});
        ex_done_q.push_back(ev_t'{tr + 1, 64'd0, 64'h0000_0000_8765_4321});
        drain("st_both");

        // Misaligned word load
        mem[64'h1000] = 64'h0123_4567_89AB_CDEF;
        issue(1, 0, 64'h1002, 2'b01, 0, 64'd0, 1, tr);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        ex_exc_q.push_back(ev_t'{tr, 64'd0, 64'd0});
        drain("ld_mis");
        chk("ld_mis.mdr_hold", MDROut, 64'h0000_0000_8765_4321);
`else
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'hFFFF_FFFF_89AB_CDEF});
        drain("ld_mis");
`endif

        // Halfword load with strobe held while busy: only one access
        issue(1, 0, 64'h1006, 2'b10, 0, 64'd0, 3, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'h0000_0000_0000_0123});
        drain("ld_h_busy");

        // Unsigned byte load
        issue(1, 0, 64'h1007, 2'b11, 1, 64'd0, 1, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'h0000_0000_0000_0001});
        drain("ld_b_u");

        // Doubleword load ignores LoadUnsigned
        issue(1, 0, 64'h1000, 2'b00, 1, 64'd0, 1, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'h0123_4567_89AB_CDEF});
        drain("ld_d");

        // Byte store into lane 5
        issue(0, 1, 64'h2005, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FF77, 1, tr);
        ex_wr_q.push_back(ev_t'{tr + 2, 64'h2000, 64'h1111_7722_3333_4444});
        ex_done_q.push_back(ev_t'{tr + 3, 64'd0, 64'h0123_4567_89AB_CDEF});
        drain("st_b");

        // Word store into upper half
        issue(0, 1, 64'h2004, 2'b01, 0, 64'h1234_5678_CAFE_BABE, 1, tr);
        ex_wr_q.push_back(ev_t'{tr + 2, 64'h2000, 64'hCAFE_BABE_3333_4444});
        ex_done_q.push_back(ev_t'{tr + 3, 64'd0, 64'h0123_4567_89AB_CDEF});
        drain("st_w");

        // Reset asserted during WR of a halfword store
        issue(0, 1, 64'h2002, 2'b10, 0, 64'hAAAA_BBBB_CCCC_1234, 1, tr);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("rst_wr.memwr_pre", 64'(MemWr), 64'd1);
        ex_wr_q.push_back(ev_t'{tr + 2, 64'h2000, 64'h1111_2222_1234_4444});
        #1;
        Reset = 1'b0;
        #1;
        chk("rst_wr.memwr", 64'(MemWr), 64'd0);
        chk("rst_wr.busy", 64'(Busy), 64'd0);
        chk("rst_wr.mdr", MDROut, 64'd0);
        @(posedge clk);
        #2;
        Reset = 1'b1;
        drain("rst_wr");

        // Load after reset release
        mem[64'h3000] = 64'h5555_6666_7777_8888;
        issue(1, 0, 64'h3000, 2'b00, 0, 64'd0, 1, tr);
        ex_done_q.push_back(ev_t'{tr + 2, 64'd0, 64'h5555_6666_7777_8888});
        drain("ld_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  system clock, all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-003 LoadMDR  in  1  load request strobe from the control unit.
REQ-004 DMemWrite  in  1  store request strobe from the control unit.
REQ-005 tam  in  2  access size: 00 doubleword, 01 word, 10 halfword, 11 byte.
REQ-006 LoadUnsigned  in  1  1 = zero-extend the loaded value; 0 = sign-extend it.
REQ-007 Address  in  64  byte address from ALUOut.
REQ-008 StoreData  in  64  store source from register B; low bytes are used for sub-doubleword stores.
REQ-009 MemAddr  out  64  doubleword-aligned memory address, {addr_q[63:3],3'b000}.
REQ-010 MemWrData  out  64  full doubleword written to memory.
REQ-011 MemWr  out  1  memory write enable.
REQ-012 MemRdData  in  64  synchronous memory read data, valid one cycle after MemAddr is presented.
REQ-013 MDROut  out  64  extended load result, registered.
REQ-014 Busy  out  1  high in every state except IDLE.
REQ-015 Done  out  1  one-cycle pulse marking completion of an access.
REQ-016 MisalignExc  out  1  one-cycle pulse when an access is misaligned; drives LoadExc/SrcExc selection.

Function
REQ-017 States: IDLE, RD, CAP, MERGE, WR, EXC, with Done raised in the cycle after a final access state.
REQ-018 IDLE: on a rising edge with LoadMDR or DMemWrite high, latch Address, tam, LoadUnsigned, StoreData and the operation type.
REQ-019 When LoadMDR and DMemWrite are both high in IDLE, the access is a store.
REQ-020 Requests arriving while Busy=1 are ignored, with no queueing.
REQ-021 Load: IDLE -> RD (MemAddr valid) -> CAP (MemRdData sampled) -> IDLE; MDROut and Done=1 are both valid in the cycle after CAP, i.e. request edge N gives Done in cycle N+3.
REQ-022 Load extraction: shift MemRdData right by addr_q[2:0]*8 bits, take the tam-sized low field, then sign- or zero-extend it to 64 bits.
REQ-023 Doubleword loads ignore LoadUnsigned.
REQ-024 Doubleword store: IDLE -> WR -> IDLE, with MemWr=1 and MemWrData=StoreData_q during WR; Done pulses in cycle N+2.
REQ-025 Sub-doubleword store (read-modify-write): IDLE -> RD -> MERGE -> WR -> IDLE.
REQ-026 In MERGE, replace only the bytes selected by tam and addr_q[2:0] in MemRdData with the low bytes of StoreData_q; all other bytes are preserved.
REQ-027 MemWr is high only in state WR, for exactly one cycle per store.
REQ-028 Sub-doubleword stores pulse Done in cycle N+4.
REQ-029 MDROut changes only on load completion and holds otherwise.
REQ-030 Misalignment conditions: halfword with addr[0]!=0; word with addr[1:0]!=0; doubleword with addr[2:0]!=0; bytes are never misaligned.

Reset
REQ-031 While Reset=0, and immediately on its assertion, the unit goes to state IDLE, including mid-operation.
REQ-032 Reset values: MemWr=0, Done=0, MisalignExc=0, Busy=0, MDROut=0, MemWrData=0, all latched request fields 0.
REQ-033 Reset during WR aborts the write; MemWr drops asynchronously and no partial Done is produced.
REQ-034 The first request is accepted on the first rising edge after Reset deasserts.

Configuration
REQ-035 Macro MEM_ACCESS_MISALIGN_CHECK_EN, when defined: a misaligned request goes IDLE -> EXC -> IDLE.
REQ-036 In EXC with the check enabled: MisalignExc=1 for one cycle, MemWr=0, MDROut unchanged, Done=0.
REQ-037 When MEM_ACCESS_MISALIGN_CHECK_EN is undefined: the EXC state is absent, MisalignExc is tied to 0, and addr_q low bits below the access size are forced to zero before extraction or merge.

Verification
REQ-038 Load byte signed: Address=0x1003, tam=11, memory dword=0x0000_0000_8000_0000 -> Done at N+3, MDROut=0xFFFF_FFFF_FFFF_FF80.
REQ-039 Load word unsigned: Address=0x1004, tam=01, LoadUnsigned=1, memory=0x8765_4321_0000_0000 -> MDROut=0x0000_0000_8765_4321.
REQ-040 Store halfword: Address=0x2002, tam=10, StoreData=0xAAAA_BBBB_CCCC_1234, memory=0x1111_2222_3333_4444 -> single MemWr at N+3 with MemWrData=0x1111_2222_1234_4444, Done at N+4.
REQ-041 Store doubleword: Address=0x3000, tam=00, StoreData=0xDEAD_BEEF_0123_4567 -> MemWr=1 only at N+1 with that data; LoadMDR+DMemWrite together at Address 0x3000 gives the same store behaviour.
REQ-042 Misaligned word load: Address=0x1002, tam=01, with MEM_ACCESS_MISALIGN_CHECK_EN -> MisalignExc pulse at N+1, no MemWr, no Done, MDROut unchanged; without the macro -> data is read from offset 0x1000 and Done at N+3.
REQ-043 Reset driven low during the WR of a halfword store -> MemWr falls immediately, Busy=0, and a load issued after release completes normally.
